// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state and owner encodings for mem_port_arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef logic [1:0] owner_t;
    localparam owner_t OWN_IF = 2'd0;
    localparam owner_t OWN_D  = 2'd1;
    localparam owner_t OWN_X  = 2'd2;
endpackage

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: winner selection; MEM_ARB_RR_EN adds a CPU/x last-served pointer
module mem_arb_grant
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic   clk,
    input  logic   reset,
    input  logic   take,
`endif
    input  logic   if_req,
    input  logic   d_req,
    input  logic   x_req,
    output owner_t owner
);
    logic cpu_req, x_wins;
    assign cpu_req = if_req | d_req;
`ifdef MEM_ARB_RR_EN
    logic last_x;
    // Track whether x took the previous grant; reset leaves the CPU group favoured
    always_ff @(posedge clk or posedge reset)
        if (reset) last_x <= 1'b1;
        else if (take) last_x <= x_wins;
    assign x_wins = x_req & (~cpu_req | ~last_x);
`else
    assign x_wins = x_req & ~cpu_req;
`endif
    // Data access always beats fetch inside the CPU group
    always_comb owner = x_wins ? OWN_X : d_req ? OWN_D : OWN_IF;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port among fetch, data and external requesters (MEM_ARB_RR_EN: round-robin CPU/x)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ack,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    input  logic                x_req,
    input  logic                x_we,
    input  logic [DATA_W/8-1:0] x_be,
    input  logic [ADDR_W-1:0]   x_addr,
    input  logic [DATA_W-1:0]   x_wdata,
    output logic                x_ack,
    output logic [DATA_W-1:0]   x_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);
    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

    state_t              state, next_state;
    owner_t              win, owner_q;
    logic                we_q, take, last_wait;
    logic [DATA_W/8-1:0] be_q;
    logic [CNT_W-1:0]    cnt;

    assign take      = (state == IDLE) & (if_req | d_req | x_req);
    assign last_wait = (state == WAIT) & (cnt == CNT_W'(1));

    mem_arb_grant u_grant (
`ifdef MEM_ARB_RR_EN
        .clk    (clk),
        .reset  (reset),
        .take   (take),
`endif
        .if_req (if_req),
        .d_req  (d_req),
        .x_req  (x_req),
        .owner  (win)
    );

    // State register
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= next_state;

    // Next state and per-state strobes; be/we are only driven while mem_en is high
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = take ? ISSUE : IDLE;
            ISSUE:   next_state = WAIT;
            WAIT:    next_state = last_wait ? RESP : WAIT;
            default: next_state = IDLE;
        endcase
        mem_en = state == ISSUE;
        mem_we = mem_en & we_q;
        mem_be = mem_en ? be_q : '0;
        busy   = state != IDLE;
        if_ack = (state == RESP) & (owner_q == OWN_IF);
        d_ack  = (state == RESP) & (owner_q == OWN_D);
        x_ack  = (state == RESP) & (owner_q == OWN_X);
    end

    // Capture the winner's command; fetch is forced to a full-word read
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            owner_q   <= OWN_IF;
            we_q      <= 1'b0;
            be_q      <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (take) begin
            owner_q   <= win;
            we_q      <= win == OWN_D ? d_we : win == OWN_X ? x_we : 1'b0;
            be_q      <= win == OWN_D ? d_be : win == OWN_X ? x_be : '1;
            mem_addr  <= win == OWN_D ? d_addr : win == OWN_X ? x_addr : if_addr;
            mem_wdata <= win == OWN_D ? d_wdata : win == OWN_X ? x_wdata : '0;
        end

    // Latency countdown and read-data capture into the owner's register
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            cnt      <= '0;
            if_rdata <= '0;
            d_rdata  <= '0;
            x_rdata  <= '0;
        end else if (state == ISSUE) begin
            cnt <= CNT_W'(WAIT_CYCLES);
        end else if (state == WAIT) begin
            cnt <= cnt - CNT_W'(1);
            if (last_wait && owner_q == OWN_IF) if_rdata <= mem_rdata;
            if (last_wait && owner_q == OWN_D) d_rdata <= mem_rdata;
            if (last_wait && owner_q == OWN_X) x_rdata <= mem_rdata;
        end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, directed corner sequences and randomized transaction-level model
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;
    localparam int W = 2;

    logic clk = 1'b0, reset = 1'b1;
    logic if_req = 0, d_req = 0, d_we = 0, x_req = 0, x_we = 0;
    logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, x_addr = 0, x_wdata = 0;
    logic [3:0] d_be = 0, x_be = 0;
    logic if_ack, d_ack, x_ack, mem_en, mem_we, busy;
    logic [31:0] if_rdata, d_rdata, x_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0] mem_be;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .x_req(x_req), .x_we(x_we), .x_be(x_be), .x_addr(x_addr), .x_wdata(x_wdata),
        .x_ack(x_ack), .x_rdata(x_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory macro model: data appears only after W cycles following the mem_en cycle
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic [7:0] raddr = 0;
    int lat = 0;
    bit rvalid = 0;
    assign mem_rdata = (rvalid && lat == 0) ? mem[raddr] : 32'hDEADBEEF;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        for (int b = 0; b < 4; b++) if (be[b]) old[8*b +: 8] = nw[8*b +: 8];
        return old;
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            raddr <= mem_addr[9:2];
            lat <= W - 1;
            rvalid <= 1'b1;
            if (mem_we) mem[mem_addr[9:2]] <= merge(mem[mem_addr[9:2]], mem_wdata, mem_be);
        end else if (lat > 0) lat <= lat - 1;
    end

    int passed = 0, total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] obs();
        return {busy, mem_en, if_ack, d_ack, x_ack};
    endfunction

    function automatic logic [31:0] rdata_of(input logic [1:0] o);
        return o == OWN_IF ? if_rdata : o == OWN_D ? d_rdata : x_rdata;
    endfunction

    task automatic clr();
        if_req = 0; d_req = 0; x_req = 0; d_we = 0; x_we = 0;
    endtask

    task automatic do_reset();
        clr();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    typedef struct {
        bit ifr, dr, xr, we;
        logic [3:0] be;
        logic [31:0] addr, wdata, rd;
        logic [1:0] own;
    } vec_t;
    vec_t v[8];

    // random-phase state, indexed by owner code
    bit rq[3];
    bit rw[3];
    logic [3:0] rb[3];
    logic [31:0] ra[3], rwd[3];
    int dk, ik, both, k, n, en_cnt, ak;
    logic [1:0] got[4];
    bit seen, m_last_x, xw, cpu, g_we;
    int g, next_ok;
    logic [1:0] own_m;
    logic [3:0] g_be;
    logic [31:0] g_addr, g_rd;

    task automatic drive_rq();
        if_req = rq[0]; if_addr = ra[0];
        d_req = rq[1]; d_we = rw[1]; d_be = rb[1]; d_addr = ra[1]; d_wdata = rwd[1];
        x_req = rq[2]; x_we = rw[2]; x_be = rb[2]; x_addr = ra[2]; x_wdata = rwd[2];
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h3C010001;
        mem[4] = 32'h11223344;
        mem[8] = 32'h0;
        mem[9] = 32'hFFFFFFFF;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];

        v[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h3000, 32'h0, 32'h3C010001, OWN_IF};
        v[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'b0100, 32'h10, 32'h00AB0000, 32'h0, OWN_D};
        v[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 32'h10, 32'h0, 32'h11AB3344, OWN_D};
        v[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 32'h20, 32'hCAFEF00D, 32'h0, OWN_X};
        v[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0, 32'hCAFEF00D, OWN_X};
        v[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'b0011, 32'h24, 32'h1234ABCD, 32'h0, OWN_D};
        v[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h24, 32'h0, 32'hFFFFABCD, OWN_IF};
        v[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 32'h3000, 32'h0, 32'h3C010001, OWN_X};

        // reset values
        #1;
        chk("reset_ctl", {55'd0, obs(), mem_we, mem_be}, 64'd0);
        chk("reset_cmd", {mem_addr, mem_wdata}, 64'd0);
        chk("reset_rdata_if_d", {if_rdata, d_rdata}, 64'd0);
        chk("reset_rdata_x", {32'd0, x_rdata}, 64'd0);
        tick();
        reset = 0;
        tick();

        // single-transaction vectors
        for (int i = 0; i < 8; i++) begin
            if_req = v[i].ifr; d_req = v[i].dr; x_req = v[i].xr;
            if_addr = v[i].addr; d_addr = v[i].addr; x_addr = v[i].addr;
            d_we = v[i].we; x_we = v[i].we; d_be = v[i].be; x_be = v[i].be;
            d_wdata = v[i].wdata; x_wdata = v[i].wdata;
            tick();
            chk("vec_issue", {55'd0, obs(), mem_we, mem_be},
                {55'd0, 5'b11000, v[i].we, v[i].own == OWN_IF ? 4'hF : v[i].be});
            chk("vec_addr", {32'd0, mem_addr}, {32'd0, v[i].addr});
            if (v[i].own != OWN_IF) chk("vec_wdata", {32'd0, mem_wdata}, {32'd0, v[i].wdata});
            tick();
            chk("vec_wait_forced", {55'd0, obs(), mem_we, mem_be}, {55'd0, 5'b10000, 1'b0, 4'h0});
            tick();
            tick();
            chk("vec_ack", {59'd0, obs()},
                {59'd0, 2'b10, v[i].own == OWN_IF, v[i].own == OWN_D, v[i].own == OWN_X});
            if (!v[i].we) chk("vec_rdata", {32'd0, rdata_of(v[i].own)}, {32'd0, v[i].rd});
            clr();
            tick();
            chk("vec_idle", {59'd0, obs()}, 64'd0);
        end

        // fetch and data together: data first, fetch after the mandatory idle cycle
        if_req = 1; if_addr = 32'h3000; d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h10;
        dk = -1; ik = -1; both = 0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (d_ack && if_ack) both++;
            if (d_ack) begin dk = c; d_req = 0; end
            if (if_ack) begin ik = c; if_req = 0; end
        end
        chk("both_d_ack_cycle", 64'(dk), 64'd4);
        chk("both_if_ack_cycle", 64'(ik), 64'd9);
        chk("both_no_overlap", 64'(both), 64'd0);
        chk("both_rdata", {if_rdata, d_rdata}, {32'h3C010001, 32'h11AB3344});

        // d and x held continuously
        do_reset();
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h10;
        x_req = 1; x_we = 0; x_be = 4'hF; x_addr = 32'h20;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            tick();
            if (d_ack) begin got[n] = OWN_D; n++; end
            else if (x_ack) begin got[n] = OWN_X; n++; end
        end
        chk("hold_grant_count", 64'(n), 64'd4);
        for (int i = 0; i < 4; i++)
`ifdef MEM_ARB_RR_EN
            chk("hold_grant_order", {62'd0, got[i]}, {62'd0, (i % 2) ? OWN_X : OWN_D});
`else
            chk("hold_grant_order", {62'd0, got[i]}, {62'd0, OWN_D});
`endif
        d_req = 0;
        seen = 0;
        for (int c = 0; c < 12 && !seen; c++) begin
            tick();
            if (x_ack) begin seen = 1; x_req = 0; end
        end
        chk("hold_x_after_d_drop", {63'd0, seen}, 64'd1);
        clr();
        tick();

        // reset pulsed during WAIT
        if_req = 1; if_addr = 32'h3000;
        tick();
        tick();
        #2 reset = 1;
        #1;
        chk("midreset_ctl", {55'd0, obs(), mem_we, mem_be}, 64'd0);
        chk("midreset_cmd_rdata", {mem_addr, if_rdata}, 64'd0);
        tick();
        chk("midreset_held", {59'd0, obs()}, 64'd0);
        reset = 0;
        k = 0;
        seen = 0;
        for (int c = 1; c <= 10 && !seen; c++) begin
            tick();
            if (if_ack) begin seen = 1; k = c; end
        end
        chk("midreset_restart_ack", 64'(k), 64'd4);
        chk("midreset_restart_rdata", {32'd0, if_rdata}, {32'd0, 32'h3C010001});
        clr();
        tick();

        // data request dropped right after capture
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h24;
        tick();
        d_req = 0;
        en_cnt = 0; ak = -1;
        for (int c = 1; c <= 10; c++) begin
            if (mem_en) en_cnt++;
            if (d_ack) ak = c;
            tick();
        end
        chk("drop_ack_cycle", 64'(ak), 64'd4);
        chk("drop_single_mem_en", 64'(en_cnt), 64'd1);
        chk("drop_rdata", {32'd0, d_rdata}, {32'd0, 32'hFFFFABCD});

        // randomized traffic against a transaction-level model
        do_reset();
        for (int i = 0; i < 3; i++) begin rq[i] = 0; rw[i] = 0; rb[i] = 4'hF; ra[i] = 0; rwd[i] = 0; end
        m_last_x = 1;
        g = -1000;
        next_ok = 0;
        own_m = OWN_IF; g_we = 0; g_be = 0; g_addr = 0; g_rd = 0;
        for (int t = 0; t < 3000; t++) begin
            chk("rand_ctl", {59'd0, obs()},
                {59'd0, t >= g + 1 && t <= g + 2 + W, t == g + 1,
                 t == g + 2 + W && own_m == OWN_IF, t == g + 2 + W && own_m == OWN_D,
                 t == g + 2 + W && own_m == OWN_X});
            if (t == g + 1)
                chk("rand_cmd", {27'd0, mem_we, mem_be, mem_addr}, {27'd0, g_we, g_be, g_addr});
            if (t == g + 2 + W) begin
                if (!g_we) chk("rand_rdata", {32'd0, rdata_of(own_m)}, {32'd0, g_rd});
                rq[own_m] = 0;
            end
            for (int r = 0; r < 3; r++)
                if (!rq[r] || (t == g + 2 + W && own_m == 2'(r)))
                    if ($urandom_range(2) == 0) begin
                        rq[r] = 1;
                        rw[r] = r != 0 && $urandom_range(1) == 1;
                        rb[r] = 4'($urandom_range(15, 1));
                        ra[r] = {22'd0, 8'($urandom_range(255, 16)), 2'b00};
                        rwd[r] = $urandom;
                    end else rq[r] = 0;
            drive_rq();
            if (t >= next_ok && (rq[0] || rq[1] || rq[2])) begin
                cpu = rq[0] || rq[1];
`ifdef MEM_ARB_RR_EN
                xw = rq[2] && (!cpu || !m_last_x);
`else
                xw = rq[2] && !cpu;
`endif
                m_last_x = xw;
                own_m = xw ? OWN_X : rq[1] ? OWN_D : OWN_IF;
                g = t;
                next_ok = t + 3 + W;
                g_we = own_m != OWN_IF && rw[own_m];
                g_be = own_m == OWN_IF ? 4'hF : rb[own_m];
                g_addr = ra[own_m];
                if (g_we) ref_mem[g_addr[9:2]] = merge(ref_mem[g_addr[9:2]], rwd[own_m], g_be);
                g_rd = ref_mem[g_addr[9:2]];
            end
            tick();
        end
        clr();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences and shares the single-port unified instruction/data memory of the multicycle MIPS core among three requesters: instruction fetch, CPU data access (lw/lb/sw/sb), and an external loader/debug port. One transaction at a time: capture the winning request, issue one memory enable, wait a fixed latency, return read data with a one-cycle acknowledge. Sits between the controller/datapath fetch and load/store paths and the memory macro.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, word width; byte enables are DATA_W/8 wide
- WAIT_CYCLES, 2, memory read latency in cycles after the mem_en cycle; legal range ≥1

Ports (reset is reset, asynchronous, active-high; clock is clk):
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- if_req / if_addr  in  1 / ADDR_W  fetch read request and address
- if_ack / if_rdata  out  1 / DATA_W  fetch acknowledge pulse and data
- d_req, d_we  in  1 each  data request; write when d_we=1
- d_be / d_addr / d_wdata  in  DATA_W/8 / ADDR_W / DATA_W  data request fields
- d_ack / d_rdata  out  1 / DATA_W  data acknowledge pulse and data
- x_req, x_we, x_be, x_addr, x_wdata  in  same widths as d_*  external port request
- x_ack / x_rdata  out  1 / DATA_W  external acknowledge pulse and data
- mem_en, mem_we  out  1 each  memory strobe; write qualifier
- mem_be / mem_addr / mem_wdata  out  DATA_W/8 / ADDR_W / DATA_W  memory command
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req is high, select winner, register owner, addr, we, be, wdata, then go to ISSUE; otherwise stay.
- Priority: d over if always. CPU group (d or if) vs x: see Configuration.
- ISSUE: mem_en=1 for exactly one cycle; mem_we = registered we; load wait counter with WAIT_CYCLES; go to WAIT.
- WAIT: decrement counter each cycle; on the edge where counter reaches 0, capture mem_rdata into the owner's rdata register and go to RESP.
- RESP: owner's ack=1 for one cycle; go to IDLE.
- Fetch is always a read; if_req ignores we/be (mem_be=all ones, mem_we=0).
- Writes use identical timing; rdata is still captured but is not meaningful.
- Requesters hold req and fields stable until ack. A req dropped after capture does not cancel; ack still pulses.
- A req still high after ack is treated as a new transaction.
- rdata registers hold their last value until overwritten.

## Timing
- Request sampled in IDLE at cycle 0 → mem_en cycle 1 → WAIT cycles 2..1+WAIT_CYCLES → ack cycle 2+WAIT_CYCLES → IDLE cycle 3+WAIT_CYCLES.
- Minimum one IDLE cycle between transactions.
- mem_we and mem_be are forced to 0 when mem_en=0. mem_addr and mem_wdata keep their registered values.
- Reset values: all acks 0, all rdata 0, mem_en/mem_we 0, mem_be/mem_addr/mem_wdata 0, busy 0, state IDLE, round-robin pointer = CPU favoured.
- Reset mid-transaction: state returns to IDLE and outputs take reset values immediately. No ack is issued. Pending reqs restart from IDLE after release.

## Configuration
- MEM_ARB_RR_EN defined: a one-bit last-served pointer. When the CPU group and x request in the same IDLE cycle, the group not served last wins. The pointer updates on every grant.
- Not defined: fixed priority, CPU group over x. x is served only in an IDLE cycle with no if_req/d_req.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - the owner encoding OWN_IF=0, OWN_D=1, OWN_X=2 (2 bits).
- Sub-module mem_arb_grant contains:
  - the combinational winner selection;
  - the round-robin pointer register (present only under MEM_ARB_RR_EN).

## Test plan
(WAIT_CYCLES=2 throughout)
- Memory word 0x3000 = 0x3C010001; if_req addr 0x3000 at cycle 0 → mem_en cycle 1, if_ack cycle 4, if_rdata=0x3C010001, busy low again cycle 5.
- sb: d_we=1, d_be=4'b0100, addr 0x10, wdata 0x00AB0000 over word 0x11223344 → mem_en, mem_we, mem_be=0100 in cycle 1; d_ack cycle 4; a later read of 0x10 returns 0x11AB3344.
- if_req and d_req both high at cycle 0 → d_ack cycle 4, if_ack cycle 9, never both in one cycle.
- d_req and x_req held high continuously → with MEM_ARB_RR_EN grants alternate d, x, d, x; without it, x_ack never pulses until d_req drops.
- reset pulsed during WAIT → all outputs at reset values, no ack; with if_req held after release, if_ack arrives 4 cycles after the first IDLE cycle.
- d_req dropped the cycle after capture → d_ack still pulses cycle 4; no second mem_en follows.
